// File: rtl/game_pkg.sv
// Shared encodings for the game-over animation and the top-level game FSM.
package game_pkg;

  typedef enum logic [2:0] {
    SEQ_OFF,
    SEQ_IDLE,
    SEQ_SPLIT,
    SEQ_FALL,
    SEQ_FADE,
    SEQ_HOLD
  } seq_state_t;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SPLIT = 2'd1;
  localparam logic [1:0] PH_FALL  = 2'd2;
  localparam logic [1:0] PH_FADE  = 2'd3;

  localparam logic [3:0] GS_MENU   = 4'b0000;
  localparam logic [3:0] GS_PLAYER = 4'b0001;
  localparam logic [3:0] GS_ENEMY  = 4'b1000;
  localparam logic [3:0] GS_OVER   = 4'b1111;

  localparam int COLOR_W = 12;
  localparam logic [3:0] LVL_MAX = 4'd15;

  function automatic logic [COLOR_W-1:0] grey(
    input logic [3:0] l
  );
    return {l, l, l};
  endfunction

endpackage

// File: rtl/game_over_sequencer_if.sv
// Trigger inputs and animation controls of the game-over sequencer.
interface game_over_sequencer_if;

  logic        frame_in;
  logic        start_in;
  logic        decide_in;
  logic        busy_out;
  logic [1:0]  phase_out;
  logic        divided_out;
  logic        fall_apart_valid_out;
  logic [11:0] font_color_out;
  logic        done_out;
  logic        restart_out;

  modport master (
    output frame_in,
    output start_in,
    output decide_in,
    input  busy_out,
    input  phase_out,
    input  divided_out,
    input  fall_apart_valid_out,
    input  font_color_out,
    input  done_out,
    input  restart_out
  );

  modport slave (
    input  frame_in,
    input  start_in,
    input  decide_in,
    output busy_out,
    output phase_out,
    output divided_out,
    output fall_apart_valid_out,
    output font_color_out,
    output done_out,
    output restart_out
  );

endinterface

// File: rtl/game_over_sequencer_frame_timer.sv
// 8-bit frame tick counter; expire fires on the tick that reaches term.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] term,
  output logic       expire
);

  logic [7:0] count;

  assign expire = tick && !clr && (count == term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= expire ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/game_over_sequencer.sv
// Game-over animation: heart idle, split, fall-apart, text fade, hold.
module game_over_sequencer
  import game_pkg::*;
#(
  parameter int IDLE_FRAMES  = 60,
  parameter int SPLIT_FRAMES = 120,
  parameter int FALL_FRAMES  = 120,
  parameter int FADE_DIV     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  game_over_sequencer_if.slave bus
);

  localparam logic [7:0] IDLE_TC  = 8'(IDLE_FRAMES - 1);
  localparam logic [7:0] SPLIT_TC = 8'(SPLIT_FRAMES - 1);
  localparam logic [7:0] FALL_TC  = 8'(FALL_FRAMES - 1);
  localparam logic [7:0] FADE_TC  = 8'(FADE_DIV - 1);

  seq_state_t state, next;

  logic [3:0] level, level_d;
  logic       decide_q, rise;

  logic       ph_clr, ph_tick, ph_exp;
  logic [7:0] ph_term;
  logic       fd_clr, fd_tick, fd_exp;

  logic               busy_q, busy_d;
  logic [1:0]         phase_q, phase_d;
  logic               div_q, div_d;
  logic               fall_q, fall_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_q, done_d;
  logic               restart_q, restart_d;

  assign rise = bus.decide_in && !decide_q;

  assign ph_clr  = (state == SEQ_OFF);
  assign ph_tick = bus.frame_in &&
                   (state == SEQ_IDLE ||
                    state == SEQ_SPLIT ||
                    state == SEQ_FALL);
  assign fd_clr  = (state != SEQ_FADE);
  assign fd_tick = bus.frame_in && (state == SEQ_FADE);

  always_comb begin
    ph_term = FALL_TC;
    unique case (1'b1)
      (state == SEQ_IDLE):  ph_term = IDLE_TC;
      (state == SEQ_SPLIT): ph_term = SPLIT_TC;
      default:              ph_term = FALL_TC;
    endcase
  end

  frame_timer u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (ph_clr),
    .tick   (ph_tick),
    .term   (ph_term),
    .expire (ph_exp)
  );

  frame_timer u_fade_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (fd_clr),
    .tick   (fd_tick),
    .term   (FADE_TC),
    .expire (fd_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEQ_OFF;
      level    <= '0;
      decide_q <= 1'b0;
    end else begin
      state    <= next;
      level    <= level_d;
      decide_q <= bus.decide_in;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      SEQ_OFF:   if (bus.start_in) next = SEQ_IDLE;
      SEQ_IDLE:  if (ph_exp) next = SEQ_SPLIT;
      SEQ_SPLIT: if (ph_exp) next = SEQ_FALL;
      SEQ_FALL:  if (ph_exp) next = SEQ_FADE;
      SEQ_FADE:
        if (fd_exp && level == LVL_MAX - 4'd1)
          next = SEQ_HOLD;
      // Leave one cycle after the restart pulse.
      SEQ_HOLD:  if (restart_q) next = SEQ_OFF;
      default:   next = SEQ_OFF;
    endcase
  end

  always_comb begin
    level_d   = level;
    busy_d    = (next != SEQ_OFF);
    phase_d   = PH_IDLE;
    div_d     = 1'b0;
    fall_d    = 1'b0;
    done_d    = (state == SEQ_FADE) &&
                (next == SEQ_HOLD);
    restart_d = (state == SEQ_HOLD) &&
                !restart_q && rise;
    unique case (next)
      SEQ_SPLIT: begin
        phase_d = PH_SPLIT;
        div_d   = 1'b1;
      end
      SEQ_FALL: begin
        phase_d = PH_FALL;
        div_d   = 1'b1;
        fall_d  = 1'b1;
      end
      SEQ_FADE, SEQ_HOLD: begin
        phase_d = PH_FADE;
        div_d   = 1'b1;
        fall_d  = 1'b1;
      end
      default: begin
        phase_d = PH_IDLE;
      end
    endcase
    if (next == SEQ_OFF || next == SEQ_IDLE) begin
      level_d = '0;
    end else if (state == SEQ_FADE && fd_exp &&
                 level != LVL_MAX) begin
      level_d = level + 4'd1;
    end
    color_d = grey(level_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= 1'b0;
      phase_q   <= PH_IDLE;
      div_q     <= 1'b0;
      fall_q    <= 1'b0;
      color_q   <= '0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      fall_q    <= fall_d;
      color_q   <= color_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

  assign bus.busy_out             = busy_q;
  assign bus.phase_out            = phase_q;
  assign bus.divided_out          = div_q;
  assign bus.fall_apart_valid_out = fall_q;
  assign bus.font_color_out       = color_q;
  assign bus.done_out             = done_q;
  assign bus.restart_out          = restart_q;

endmodule
